// File: rtl/cos_pkg.sv
// Shared definitions for the cosine-similarity multiply sequencer.
//   - cos_state_e : sequencer FSM states
//   - SLOT_*      : result slot encodings carried in the return tag
//   - EXP_*       : FP32 exponent field position and all-ones value
//   - is_exp_max  : true when an FP32 word carries the all-ones exponent
package cos_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISS_AB = 3'd1,
        ISS_AA = 3'd2,
        ISS_BB = 3'd3,
        DRAIN  = 3'd4,
        HOLD   = 3'd5
    } cos_state_e;

    localparam logic [1:0] SLOT_AB = 2'd0;
    localparam logic [1:0] SLOT_AA = 2'd1;
    localparam logic [1:0] SLOT_BB = 2'd2;

    localparam int         EXP_MSB = 30;
    localparam int         EXP_LSB = 23;
    localparam logic [7:0] EXP_MAX = 8'hff;

    // Infinity or NaN: exponent field saturated.
    function automatic logic is_exp_max(input logic [31:0] v);
        return (v[EXP_MSB:EXP_LSB] == EXP_MAX);
    endfunction

endpackage

// File: rtl/cos_tag_pipe.sv
// Fixed-depth delay line for the multiplier return tags.
//   clk, rst : clock and asynchronous active-high reset (clears every stage)
//   d        : tag entering the pipe in the issue cycle
//   q        : tag leaving the pipe DEPTH cycles later
// DEPTH=0 makes the pipe a combinational pass-through.
module cos_tag_pipe #(
    parameter int DEPTH = 0,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_s;
            assign unused_s = clk ^ rst;
            assign q        = d;
        end else begin : g_pipe
            logic [W-1:0] stage_r [DEPTH];

            // Shift register; reset invalidates every in-flight tag.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= {W{1'b0}};
                    end
                end else begin
                    stage_r[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign q = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/cos_mul_seq.sv
// Time-shares one FP32 multiplier across a*b, a*a and b*b for each accepted
// element pair and returns the three products as one result beat.
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid/in_ready         : element pair handshake (in_a, in_b, in_last)
//   mul_a/mul_b/mul_vld       : multiplier operands and issue strobe
//   mul_p                     : product, valid MUL_LAT cycles after issue
//   out_valid/out_ready       : result beat handshake
//   out_ab/out_aa/out_bb      : products of the beat
//   out_last/out_idx          : last flag and 0-based element index
// Optional macro COSSEQ_OVF_EN adds output ovf, a sticky flag set by any
// product with a saturated exponent and cleared at the end of a vector.
module cos_mul_seq #(
    parameter int MUL_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_last,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic             mul_vld,
    input  logic [31:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_ab,
    output logic [31:0]      out_aa,
    output logic [31:0]      out_bb,
    output logic             out_last,
    output logic [CNT_W-1:0] out_idx
`ifdef COSSEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    import cos_pkg::*;

    localparam int DCW   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int TAG_W = 3;

    cos_state_e       state_r, state_s;
    logic [31:0]      a_r, b_r;
    logic [DCW-1:0]   drain_r;
    logic [CNT_W-1:0] idx_r;
    logic [1:0]       slot_r, slot_s;
    logic [31:0]      mul_a_s, mul_b_s;
    logic             mul_vld_s;
    logic             accept_s, hs_s, cap_s;
    logic [TAG_W-1:0] tag_d_s, tag_q_s;

    assign accept_s = in_valid && in_ready;
    assign hs_s     = out_valid && out_ready;
    assign tag_d_s  = {mul_vld, slot_r};
    assign cap_s    = tag_q_s[2];

    cos_tag_pipe #(.DEPTH(MUL_LAT), .W(TAG_W)) u_tag (
        .clk (clk),
        .rst (rst),
        .d   (tag_d_s),
        .q   (tag_q_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (accept_s) state_s = ISS_AB; else state_s = IDLE;
            ISS_AB:  state_s = ISS_AA;
            ISS_AA:  state_s = ISS_BB;
            ISS_BB:  if (MUL_LAT == 0) state_s = HOLD; else state_s = DRAIN;
            DRAIN:   if (drain_r == {DCW{1'b0}}) state_s = HOLD; else state_s = DRAIN;
            HOLD:    if (hs_s) state_s = IDLE; else state_s = HOLD;
            default: state_s = IDLE;
        endcase
    end

    // Operands for the coming cycle, decoded from the next state so they can
    // be registered. ISS_AB is only entered on accept, when a_r/b_r are
    // loaded in the same edge, so the raw inputs are used there.
    always_comb begin
        mul_vld_s = 1'b0;
        mul_a_s   = 32'd0;
        mul_b_s   = 32'd0;
        slot_s    = SLOT_AB;
        case (state_s)
            ISS_AB: begin
                mul_vld_s = 1'b1;
                mul_a_s   = in_a;
                mul_b_s   = in_b;
                slot_s    = SLOT_AB;
            end
            ISS_AA: begin
                mul_vld_s = 1'b1;
                mul_a_s   = a_r;
                mul_b_s   = a_r;
                slot_s    = SLOT_AA;
            end
            ISS_BB: begin
                mul_vld_s = 1'b1;
                mul_a_s   = b_r;
                mul_b_s   = b_r;
                slot_s    = SLOT_BB;
            end
            default: begin
                mul_vld_s = 1'b0;
            end
        endcase
    end

    // State register and registered handshake/operand outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mul_vld   <= 1'b0;
            mul_a     <= 32'd0;
            mul_b     <= 32'd0;
            slot_r    <= SLOT_AB;
        end else begin
            state_r   <= state_s;
            in_ready  <= (state_s == IDLE);
            out_valid <= (state_s == HOLD);
            mul_vld   <= mul_vld_s;
            mul_a     <= mul_a_s;
            mul_b     <= mul_b_s;
            slot_r    <= slot_s;
        end
    end

    // Drain down-counter: loaded as the last issue leaves, runs MUL_LAT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_r <= {DCW{1'b0}};
        end else if (state_r == ISS_BB) begin
            drain_r <= DCW'(MUL_LAT - 1);
        end else if ((state_r == DRAIN) && (drain_r != {DCW{1'b0}})) begin
            drain_r <= drain_r - DCW'(1);
        end else begin
            drain_r <= drain_r;
        end
    end

    // Pair capture and element index; the index restarts after a last pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            out_last <= 1'b0;
            out_idx  <= {CNT_W{1'b0}};
            idx_r    <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            a_r      <= in_a;
            b_r      <= in_b;
            out_last <= in_last;
            out_idx  <= idx_r;
            idx_r    <= in_last ? {CNT_W{1'b0}} : (idx_r + CNT_W'(1));
        end else begin
            a_r      <= a_r;
            b_r      <= b_r;
            out_last <= out_last;
            out_idx  <= out_idx;
            idx_r    <= idx_r;
        end
    end

    // Product capture steered by the tag emerging alongside mul_p.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ab <= 32'd0;
            out_aa <= 32'd0;
            out_bb <= 32'd0;
        end else if (cap_s) begin
            case (tag_q_s[1:0])
                SLOT_AB: out_ab <= mul_p;
                SLOT_AA: out_aa <= mul_p;
                SLOT_BB: out_bb <= mul_p;
                default: out_ab <= out_ab;
            endcase
        end else begin
            out_ab <= out_ab;
        end
    end

`ifdef COSSEQ_OVF_EN
    logic beat_ovf_r;

    // Per-beat overflow tracking and the sticky per-vector flag. Closing a
    // vector reloads the flag with the closing beat's own status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_ovf_r <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (accept_s) begin
                beat_ovf_r <= 1'b0;
            end else if (cap_s && is_exp_max(mul_p)) begin
                beat_ovf_r <= 1'b1;
            end else begin
                beat_ovf_r <= beat_ovf_r;
            end
            if (hs_s && out_last) begin
                ovf <= beat_ovf_r;
            end else if (cap_s && is_exp_max(mul_p)) begin
                ovf <= 1'b1;
            end else begin
                ovf <= ovf;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cos_mul_seq.sv
// Bench for cos_mul_seq: dut0 with MUL_LAT=0/CNT_W=16, dut1 with
// MUL_LAT=2/CNT_W=2. A transaction-level model per DUT predicts handshakes,
// operand issue, latency and products every cycle; directed checks pin
// literal results.
module tb_cos_mul_seq;

    localparam int L0 = 0;
    localparam int CW0 = 16;
    localparam int L1 = 2;
    localparam int CW1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]        in_valid_w = 2'b00;
    logic [1:0][31:0]  in_a_w = '0;
    logic [1:0][31:0]  in_b_w = '0;
    logic [1:0]        in_last_w = 2'b00;
    logic [1:0]        out_ready_w = 2'b11;
    wire  [1:0]        in_ready_w, mul_vld_w, out_valid_w, out_last_w;
    wire  [1:0][31:0]  mul_a_w, mul_b_w, out_ab_w, out_aa_w, out_bb_w;
    wire  [CW0-1:0]    idx0_w;
    wire  [CW1-1:0]    idx1_w;
    wire  [31:0]       mul_p0;
    wire  [31:0]       mul_p1;
    wire  [1:0]        ovf_w;
    logic [31:0]       mp1_r [L1];

    int n_pass = 0;
    int n_tot  = 0;

    // Reference FP32 multiply for normal operands (truncating, saturates to inf).
    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          e;
        logic [47:0] m;
        s = x[31] ^ y[31];
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        m = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        if (m[47]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {s, 8'hff, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), m[45:23]};
    endfunction

    assign mul_p0 = fmul(mul_a_w[0], mul_b_w[0]);
    assign mul_p1 = mp1_r[L1-1];

    always @(posedge clk) begin
        mp1_r[0] <= fmul(mul_a_w[1], mul_b_w[1]);
        for (int i = 1; i < L1; i++) mp1_r[i] <= mp1_r[i-1];
    end

    cos_mul_seq #(.MUL_LAT(L0), .CNT_W(CW0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
        .in_a(in_a_w[0]), .in_b(in_b_w[0]), .in_last(in_last_w[0]),
        .mul_a(mul_a_w[0]), .mul_b(mul_b_w[0]), .mul_vld(mul_vld_w[0]), .mul_p(mul_p0),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_w[0]),
        .out_ab(out_ab_w[0]), .out_aa(out_aa_w[0]), .out_bb(out_bb_w[0]),
        .out_last(out_last_w[0]),
`ifdef COSSEQ_OVF_EN
        .ovf(ovf_w[0]),
`endif
        .out_idx(idx0_w)
    );

    cos_mul_seq #(.MUL_LAT(L1), .CNT_W(CW1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
        .in_a(in_a_w[1]), .in_b(in_b_w[1]), .in_last(in_last_w[1]),
        .mul_a(mul_a_w[1]), .mul_b(mul_b_w[1]), .mul_vld(mul_vld_w[1]), .mul_p(mul_p1),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_w[1]),
        .out_ab(out_ab_w[1]), .out_aa(out_aa_w[1]), .out_bb(out_bb_w[1]),
        .out_last(out_last_w[1]),
`ifdef COSSEQ_OVF_EN
        .ovf(ovf_w[1]),
`endif
        .out_idx(idx1_w)
    );

`ifndef COSSEQ_OVF_EN
    assign ovf_w = 2'b00;
`endif

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tot = n_tot + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s dut%0d: got %h, expected %h", name, d, act, exp);
    endtask

    task automatic fail_now(input string name, input int d);
        n_tot = n_tot + 1;
        $display("FAIL %s dut%0d: wait bound expired", name, d);
    endtask

    // ---------------- transaction-level model + compare ----------------
    int          lat_p [2] = '{L0, L1};
    int          cw_p  [2] = '{CW0, CW1};
    logic        busy_m [2];
    int          acc_m  [2];
    int          rise_m [2];
    int          idx_m  [2];
    logic        prev_ov [2];
    logic [31:0] ma [2];
    logic [31:0] mb [2];
    logic        mlast [2];
    int          midx [2];
    int          cyc = 0;
    int          log_idx [$];
    int          log_last [$];
    int          log_lat [$];

    always @(negedge clk) begin
        int          k;
        logic        vld_e, ov_e;
        logic [31:0] ea, eb, oidx;
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            oidx = (d == 0) ? 32'(idx0_w) : 32'(idx1_w);
            if (rst) begin
                busy_m[d]  = 1'b0;
                idx_m[d]   = 0;
                prev_ov[d] = 1'b0;
                chk("rst_in_ready", d, 32'(in_ready_w[d]), 32'd1);
                chk("rst_mul_vld", d, 32'(mul_vld_w[d]), 32'd0);
                chk("rst_mul_a", d, mul_a_w[d], 32'd0);
                chk("rst_mul_b", d, mul_b_w[d], 32'd0);
                chk("rst_out_valid", d, 32'(out_valid_w[d]), 32'd0);
                chk("rst_out_ab", d, out_ab_w[d], 32'd0);
                chk("rst_out_aa", d, out_aa_w[d], 32'd0);
                chk("rst_out_bb", d, out_bb_w[d], 32'd0);
                chk("rst_out_last", d, 32'(out_last_w[d]), 32'd0);
                chk("rst_out_idx", d, oidx, 32'd0);
                chk("rst_ovf", d, 32'(ovf_w[d]), 32'd0);
            end else begin
                k     = cyc - acc_m[d];
                vld_e = busy_m[d] && (k >= 1) && (k <= 3);
                ov_e  = busy_m[d] && (k >= 4 + lat_p[d]);
                ea = 32'd0;
                eb = 32'd0;
                if (vld_e && k == 1) begin ea = ma[d]; eb = mb[d]; end
                if (vld_e && k == 2) begin ea = ma[d]; eb = ma[d]; end
                if (vld_e && k == 3) begin ea = mb[d]; eb = mb[d]; end
                chk("in_ready", d, 32'(in_ready_w[d]), 32'(!busy_m[d]));
                chk("mul_vld", d, 32'(mul_vld_w[d]), 32'(vld_e));
                chk("mul_a", d, mul_a_w[d], ea);
                chk("mul_b", d, mul_b_w[d], eb);
                chk("out_valid", d, 32'(out_valid_w[d]), 32'(ov_e));
                if (ov_e) begin
                    chk("out_ab", d, out_ab_w[d], fmul(ma[d], mb[d]));
                    chk("out_aa", d, out_aa_w[d], fmul(ma[d], ma[d]));
                    chk("out_bb", d, out_bb_w[d], fmul(mb[d], mb[d]));
                    chk("out_last", d, 32'(out_last_w[d]), 32'(mlast[d]));
                    chk("out_idx", d, oidx, 32'(midx[d]));
                end
                if (out_valid_w[d] && !prev_ov[d]) rise_m[d] = cyc;
                prev_ov[d] = out_valid_w[d];
                // Events taking effect at the coming rising edge.
                if (ov_e && out_ready_w[d]) begin
                    busy_m[d] = 1'b0;
                    if (d == 1) begin
                        log_idx.push_back(midx[d]);
                        log_last.push_back(int'(mlast[d]));
                        log_lat.push_back(rise_m[d] - acc_m[d]);
                    end
                end else if (!busy_m[d] && in_valid_w[d]) begin
                    busy_m[d] = 1'b1;
                    acc_m[d]  = cyc;
                    ma[d]     = in_a_w[d];
                    mb[d]     = in_b_w[d];
                    mlast[d]  = in_last_w[d];
                    midx[d]   = idx_m[d];
                    idx_m[d]  = in_last_w[d] ? 0 : ((idx_m[d] + 1) % (1 << cw_p[d]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, input logic last);
        int n;
        n = 0;
        in_valid_w[d] = 1'b1;
        in_a_w[d]     = a;
        in_b_w[d]     = b;
        in_last_w[d]  = last;
        @(negedge clk);
        while (!in_ready_w[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("send_wait", d);
        @(posedge clk);
        #1;
        in_valid_w[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready_w[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("idle_wait", d);
        @(posedge clk);
        #1;
    endtask

    int exp_idx  [12] = '{0, 1, 2, 3, 0, 0, 0, 0, 1, 2, 3, 0};
    int exp_last [12] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // MUL_LAT=0: 2.0 x 3.0, result valid in cycle 4 after accept.
        send(0, 32'h40000000, 32'h40400000, 1'b0);
        repeat (3) @(negedge clk);
        chk("lat0_early", 0, 32'(out_valid_w[0]), 32'd0);
        @(negedge clk);
        chk("lat0_valid", 0, 32'(out_valid_w[0]), 32'd1);
        chk("lat0_ab", 0, out_ab_w[0], 32'h40C00000);
        chk("lat0_aa", 0, out_aa_w[0], 32'h40800000);
        chk("lat0_bb", 0, out_bb_w[0], 32'h41100000);
        chk("lat0_idx", 0, 32'(idx0_w), 32'd0);
        wait_idle(0);
        send(0, 32'h3FC00000, 32'hC0000000, 1'b1);
        send(0, 32'h41200000, 32'h3F000000, 1'b0);
        wait_idle(0);

        // MUL_LAT=2: four pairs closing a vector, then one more.
        send(1, 32'h3F800000, 32'h40000000, 1'b0);
        send(1, 32'h40000000, 32'h40400000, 1'b0);
        send(1, 32'hC0000000, 32'h40400000, 1'b0);
        send(1, 32'h3FC00000, 32'h40800000, 1'b1);
        send(1, 32'h41200000, 32'h3F000000, 1'b1);
        wait_idle(1);

        // Stall in HOLD for 10 cycles with ignored input pulses.
        out_ready_w[1] = 1'b0;
        send(1, 32'h3F800000, 32'h40000000, 1'b1);
        n = 0;
        while (!out_valid_w[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("hold_wait", 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid_w[1] = i[0];
            in_a_w[1]     = 32'hDEADBEEF;
            in_b_w[1]     = 32'h12345678;
            @(negedge clk);
            chk("hold_in_ready", 1, 32'(in_ready_w[1]), 32'd0);
            chk("hold_valid", 1, 32'(out_valid_w[1]), 32'd1);
            chk("hold_ab", 1, out_ab_w[1], 32'h40000000);
            chk("hold_bb", 1, out_bb_w[1], 32'h40800000);
        end
        @(posedge clk);
        #1;
        in_valid_w[1]  = 1'b0;
        out_ready_w[1] = 1'b1;
        wait_idle(1);

        // Reset while issuing a*a; stale products must not leak in.
        send(1, 32'h40400000, 32'h40A00000, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 1, 32'(in_ready_w[1]), 32'd1);
        chk("midrst_mul_vld", 1, 32'(mul_vld_w[1]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(1, 32'h3FC00000, 32'h40800000, 1'b1);
        @(negedge clk);
        chk("stale_ab_c4", 1, out_ab_w[1], 32'd0);
        @(negedge clk);
        chk("stale_ab_c5", 1, out_ab_w[1], 32'd0);
        wait_idle(1);

        // Index wrap with CNT_W=2.
        send(1, 32'h3F800000, 32'h3F800000, 1'b0);
        send(1, 32'h40000000, 32'h3F800000, 1'b0);
        send(1, 32'h40400000, 32'h40000000, 1'b0);
        send(1, 32'h40800000, 32'hBF800000, 1'b0);
        send(1, 32'h3F000000, 32'h40400000, 1'b0);
        wait_idle(1);

        chk("log_size", 1, 32'(log_idx.size()), 32'd12);
        for (int i = 0; i < 12 && i < log_idx.size(); i++) begin
            chk("beat_idx", 1, 32'(log_idx[i]), 32'(exp_idx[i]));
            chk("beat_last", 1, 32'(log_last[i]), 32'(exp_last[i]));
            chk("beat_latency", 1, 32'(log_lat[i]), 32'd6);
        end

`ifdef COSSEQ_OVF_EN
        send(1, 32'h7F000000, 32'h7F000000, 1'b0);
        wait_idle(1);
        chk("ovf_set", 1, 32'(ovf_w[1]), 32'd1);
        send(1, 32'h3F800000, 32'h40000000, 1'b0);
        wait_idle(1);
        chk("ovf_sticky", 1, 32'(ovf_w[1]), 32'd1);
        send(1, 32'h3F800000, 32'h40000000, 1'b1);
        wait_idle(1);
        chk("ovf_clear", 1, 32'(ovf_w[1]), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog dut0: simulation time bound expired");
        $fatal(1, "watchdog");
    end

endmodule
